// File: rtl/bus_irq_ctrl.sv
// Interrupt controller on the internal bus: up to 32 edge/level sources, W1C status,
// enable mask and a holdoff counter that coalesces bursts of new events into one irq rise.
module bus_irq_ctrl #(
   parameter int unsigned ADDR           = 0,
   parameter int unsigned DATAWIDTH      = 32,
   parameter logic [31:0] EDGE_MASK      = '1,
   parameter int unsigned HOLDOFF        = 15,
   parameter int unsigned CNTW           = 4,
   parameter bit          BUS_IRQ        = 1'b0,
   parameter int unsigned BUS_ADDR_WIDTH = 16
) (
   input  logic                      bus_clk,
   input  logic                      bus_reset_l,
   input  logic [BUS_ADDR_WIDTH-1:0] bus_addr,
   input  logic                      bus_re,
   input  logic                      bus_we,
   input  logic [31:0]               bus_wr_data,
   output logic [31:0]               bus_rd_data,
   output logic                      bus_rd_ack,
   output logic                      bus_wr_ack,
   output logic                      bus_irq,
   input  logic [DATAWIDTH-1:0]      trig,
   output logic                      irq
);

   localparam logic [BUS_ADDR_WIDTH-1:0] BASE = BUS_ADDR_WIDTH'(ADDR);
   localparam logic [DATAWIDTH-1:0]      EDGE = EDGE_MASK[DATAWIDTH-1:0];

   if (ADDR % 16 != 0) begin : g_addr_chk
      $error("bus_irq_ctrl: ADDR must be 16-byte aligned");
   end
   if (DATAWIDTH < 1 || DATAWIDTH > 32) begin : g_dw_chk
      $error("bus_irq_ctrl: DATAWIDTH must be 1..32");
   end
   if (HOLDOFF > (2 ** CNTW) - 1) begin : g_cnt_chk
      $error("bus_irq_ctrl: HOLDOFF does not fit in CNTW bits");
   end

   logic [DATAWIDTH-1:0] sync_q, s_q, prev_q, status_q, enable_q;
   logic [CNTW-1:0]      count_q;
   logic                 irq_q, rd_ack_q, wr_ack_q;
   logic [31:0]          rd_data_q;

   logic                 hit, re_hit, we_hit, new_evt;
   logic [1:0]           off;
   logic [DATAWIDTH-1:0] set, w1c, rd_mux;

   assign hit    = bus_addr[BUS_ADDR_WIDTH-1:4] == BASE[BUS_ADDR_WIDTH-1:4];
   assign off    = bus_addr[3:2];
   assign re_hit = bus_re && hit;
   assign we_hit = bus_we && hit;

   // Edge bits fire on a 0->1 of the synchronised input; level bits keep setting while high.
   assign set     = (s_q & ~prev_q & EDGE) | (s_q & ~EDGE);
   assign w1c     = (we_hit && off == 2'd0) ? bus_wr_data[DATAWIDTH-1:0] : '0;
   assign new_evt = |(set & ~status_q);

   always_comb begin
      rd_mux = '0;
      unique case (off)
         2'd0:    rd_mux = status_q;
         2'd1:    rd_mux = enable_q;
         2'd2:    rd_mux = s_q;
         default: rd_mux = status_q & enable_q;
      endcase
   end

   always_ff @(posedge bus_clk or negedge bus_reset_l) begin
      if (!bus_reset_l) begin
         sync_q    <= '0;
         s_q       <= '0;
         prev_q    <= '0;
         status_q  <= '0;
         enable_q  <= '0;
         count_q   <= '0;
         irq_q     <= 1'b0;
         rd_ack_q  <= 1'b0;
         wr_ack_q  <= 1'b0;
         rd_data_q <= '0;
      end else begin
         sync_q   <= trig;
         s_q      <= sync_q;
         prev_q   <= s_q;
         status_q <= (status_q & ~w1c) | set;
         if (we_hit && off == 2'd1) begin
            enable_q <= bus_wr_data[DATAWIDTH-1:0];
         end
         if (new_evt) begin
            count_q <= CNTW'(HOLDOFF);
         end else if (count_q != '0) begin
            count_q <= count_q - 1'b1;
         end
         irq_q     <= (count_q == '0) && |(status_q & enable_q);
         rd_ack_q  <= re_hit;
         wr_ack_q  <= we_hit;
         rd_data_q <= re_hit ? 32'(rd_mux) : 32'd0;
      end
   end

   assign irq         = irq_q;
   assign bus_irq     = BUS_IRQ ? irq_q : 1'b0;
   assign bus_rd_ack  = rd_ack_q;
   assign bus_wr_ack  = wr_ack_q;
   assign bus_rd_data = rd_data_q;

   logic unused_bits;
   assign unused_bits = ^{bus_addr[1:0], bus_wr_data};

endmodule

// File: tb/tb_bus_irq_ctrl.sv
// Bench for bus_irq_ctrl: register-access vector table, directed timing sequences and a
// randomized run against a cycle-counting reference model.
module tb_bus_irq_ctrl;

   localparam int unsigned DW = 24;
   localparam int unsigned H  = 15;
   localparam logic [31:0] EM = 32'hFFFF_FFEF;
   localparam logic [15:0] A_ST = 16'h0040;
   localparam logic [15:0] A_EN = 16'h0044;
   localparam logic [15:0] A_RAW = 16'h0048;
   localparam logic [15:0] A_MSK = 16'h004C;

   logic          bus_clk, bus_reset_l;
   logic [15:0]   bus_addr;
   logic          bus_re, bus_we;
   logic [31:0]   bus_wr_data, bus_rd_data;
   logic          bus_rd_ack, bus_wr_ack, bus_irq, irq;
   logic [DW-1:0] trig;

   int checks = 0;
   int errors = 0;

   bus_irq_ctrl #(
      .ADDR(32'h40), .DATAWIDTH(DW), .EDGE_MASK(EM), .HOLDOFF(H), .CNTW(4), .BUS_IRQ(1'b1),
      .BUS_ADDR_WIDTH(16)
   ) dut (
      .bus_clk(bus_clk), .bus_reset_l(bus_reset_l), .bus_addr(bus_addr), .bus_re(bus_re),
      .bus_we(bus_we), .bus_wr_data(bus_wr_data), .bus_rd_data(bus_rd_data),
      .bus_rd_ack(bus_rd_ack), .bus_wr_ack(bus_wr_ack), .bus_irq(bus_irq), .trig(trig),
      .irq(irq)
   );

   initial bus_clk = 1'b0;
   always #5 bus_clk = ~bus_clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge bus_clk);
      #1;
   endtask

   task automatic bus_write(input logic [15:0] a, input logic [31:0] d);
      bus_addr = a; bus_wr_data = d; bus_we = 1'b1;
      tick();
      chk("wr_ack", 32'(bus_wr_ack), 32'd1);
      bus_we = 1'b0;
   endtask

   task automatic read_chk(input string name, input logic [15:0] a, input logic [31:0] exp);
      bus_addr = a; bus_re = 1'b1;
      tick();
      chk({name, "_ack"}, 32'(bus_rd_ack), 32'd1);
      chk(name, bus_rd_data, exp);
      bus_re = 1'b0;
   endtask

   typedef struct {
      logic        we;
      logic        re;
      logic [15:0] addr;
      logic [31:0] wdata;
      logic        exp_rack;
      logic        exp_wack;
      logic [31:0] exp_rdata;
   } vec_t;

   vec_t vecs[12];

   // Reference model: synchroniser as a trig history, holdoff as "cycles since last new event".
   logic [DW-1:0] m_hist[3];
   logic [DW-1:0] m_status, m_enable;
   int            m_cyc, m_last;
   logic          e_irq, e_rack, e_wack;
   logic [31:0]   e_rdata;

   task automatic model_reset();
      for (int i = 0; i < 3; i++) m_hist[i] = '0;
      m_status = '0; m_enable = '0; m_cyc = 0; m_last = -1000;
   endtask

   task automatic model_step();
      logic [DW-1:0] s, prev, set, w1c, edge_bits;
      logic          hit;
      logic [1:0]    off;
      edge_bits = EM[DW-1:0];
      s    = m_hist[1];
      prev = m_hist[2];
      set  = 0;
      for (int i = 0; i < DW; i++) begin
         set[i] = edge_bits[i] ? (s[i] && !prev[i]) : s[i];
      end
      hit = (bus_addr >> 4) == (A_ST >> 4);
      off = bus_addr[3:2];
      e_irq   = ((m_cyc - m_last) > int'(H)) && ((m_status & m_enable) != 0);
      e_rack  = bus_re && hit;
      e_wack  = bus_we && hit;
      e_rdata = 0;
      if (e_rack) begin
         case (off)
            2'd0: e_rdata = 32'(m_status);
            2'd1: e_rdata = 32'(m_enable);
            2'd2: e_rdata = 32'(s);
            default: e_rdata = 32'(m_status & m_enable);
         endcase
      end
      w1c = (e_wack && off == 2'd0) ? bus_wr_data[DW-1:0] : '0;
      if ((set & ~m_status) != 0) m_last = m_cyc;
      m_status = (m_status & ~w1c) | set;
      if (e_wack && off == 2'd1) m_enable = bus_wr_data[DW-1:0];
      m_hist[2] = m_hist[1];
      m_hist[1] = m_hist[0];
      m_hist[0] = trig;
      m_cyc++;
   endtask

   initial begin
      logic early;
      bus_reset_l = 1'b0; trig = '0; bus_addr = A_ST; bus_re = 1'b0; bus_we = 1'b0;
      bus_wr_data = '0;

      // Reset held: trig activity and a read request must produce nothing.
      bus_re = 1'b1;
      for (int i = 0; i < 3; i++) begin
         trig = '1; tick(); trig = '0; tick();
      end
      chk("rst_irq", 32'(irq), 32'd0);
      chk("rst_bus_irq", 32'(bus_irq), 32'd0);
      chk("rst_rd_ack", 32'(bus_rd_ack), 32'd0);
      bus_re = 1'b0;
      bus_reset_l = 1'b1;
      tick(); tick();
      bus_addr = A_ST; bus_re = 1'b1;
      chk("ack_not_early", 32'(bus_rd_ack), 32'd0);
      tick();
      chk("ack_one_late", 32'(bus_rd_ack), 32'd1);
      bus_re = 1'b0;
      read_chk("rst_status", A_ST, 32'd0);
      read_chk("rst_enable", A_EN, 32'd0);
      read_chk("rst_raw", A_RAW, 32'd0);
      read_chk("rst_masked", A_MSK, 32'd0);

      // Register map vectors; trig idle, status empty.
      vecs[0]  = '{1'b1, 1'b0, A_EN,     32'hFFFF_FFFF, 1'b0, 1'b1, 32'h0};
      vecs[1]  = '{1'b0, 1'b1, A_EN,     32'h0,         1'b1, 1'b0, 32'h00FF_FFFF};
      vecs[2]  = '{1'b1, 1'b0, A_RAW,    32'h5,         1'b0, 1'b1, 32'h0};
      vecs[3]  = '{1'b0, 1'b1, A_RAW,    32'h0,         1'b1, 1'b0, 32'h0};
      vecs[4]  = '{1'b1, 1'b0, A_MSK,    32'hFF,        1'b0, 1'b1, 32'h0};
      vecs[5]  = '{1'b0, 1'b1, A_MSK,    32'h0,         1'b1, 1'b0, 32'h0};
      vecs[6]  = '{1'b0, 1'b1, A_ST,     32'h0,         1'b1, 1'b0, 32'h0};
      vecs[7]  = '{1'b0, 1'b1, 16'h0050, 32'h0,         1'b0, 1'b0, 32'h0};
      vecs[8]  = '{1'b1, 1'b0, 16'h0054, 32'h0,         1'b0, 1'b0, 32'h0};
      vecs[9]  = '{1'b0, 1'b1, A_EN,     32'h0,         1'b1, 1'b0, 32'h00FF_FFFF};
      vecs[10] = '{1'b1, 1'b0, A_EN,     32'h0,         1'b0, 1'b1, 32'h0};
      vecs[11] = '{1'b0, 1'b1, A_EN,     32'h0,         1'b1, 1'b0, 32'h0};
      for (int i = 0; i < 12; i++) begin
         bus_we = vecs[i].we; bus_re = vecs[i].re;
         bus_addr = vecs[i].addr; bus_wr_data = vecs[i].wdata;
         tick();
         chk($sformatf("vec%0d_rack", i), 32'(bus_rd_ack), 32'(vecs[i].exp_rack));
         chk($sformatf("vec%0d_wack", i), 32'(bus_wr_ack), 32'(vecs[i].exp_wack));
         chk($sformatf("vec%0d_rdata", i), bus_rd_data, vecs[i].exp_rdata);
         bus_we = 1'b0; bus_re = 1'b0;
      end

      // Edge pulse: STATUS visible after 3 edges, irq after HOLDOFF+1 more.
      bus_write(A_EN, 32'h1);
      tick(); tick();
      trig[0] = 1'b1;
      tick();
      trig = '0; bus_addr = A_ST; bus_re = 1'b1;
      tick();
      tick();
      chk("t2_status_pre", bus_rd_data, 32'd0);
      tick();
      chk("t2_status_set", bus_rd_data, 32'd1);
      bus_re = 1'b0;
      repeat (14) tick();
      chk("t2_irq_early", 32'(irq), 32'd0);
      tick();
      chk("t2_irq_rise", 32'(irq), 32'd1);
      chk("t2_bus_irq", 32'(bus_irq), 32'd1);
      bus_write(A_ST, 32'h1);
      chk("t2_irq_hold", 32'(irq), 32'd1);
      tick();
      chk("t2_irq_fall", 32'(irq), 32'd0);

      // Level source: W1C ineffective while high, clears once dropped.
      trig[4] = 1'b1;
      repeat (5) tick();
      bus_write(A_ST, 32'h10);
      read_chk("t3_level_sticky", A_ST, 32'h10);
      trig[4] = 1'b0;
      repeat (5) tick();
      bus_write(A_ST, 32'h10);
      read_chk("t3_level_clear", A_ST, 32'h0);
      chk("t3_irq", 32'(irq), 32'd0);

      // Coalescing: three pulses 10 cycles apart give one rise 16 after the last set.
      bus_write(A_EN, 32'h7);
      repeat (20) tick();
      early = 1'b0;
      trig = 24'h1;
      for (int c = 1; c <= 39; c++) begin
         tick();
         if (c == 1 || c == 11 || c == 21) trig = '0;
         if (c == 10) trig = 24'h2;
         if (c == 20) trig = 24'h4;
         if (c < 39 && irq) early = 1'b1;
      end
      chk("t4_no_early_irq", 32'(early), 32'd0);
      chk("t4_irq_rise", 32'(irq), 32'd1);
      read_chk("t4_status", A_ST, 32'h7);
      bus_write(A_ST, 32'h7);
      tick();
      chk("t4_irq_fall", 32'(irq), 32'd0);

      // Masking and enabling an already-pending bit.
      bus_write(A_EN, 32'h0);
      trig = 24'h3;
      tick();
      trig = '0;
      repeat (20) tick();
      chk("t5_irq_masked", 32'(irq), 32'd0);
      read_chk("t5_masked0", A_MSK, 32'h0);
      read_chk("t5_status", A_ST, 32'h3);
      bus_write(A_EN, 32'h2);
      chk("t5_irq_pre", 32'(irq), 32'd0);
      tick();
      chk("t5_irq_enabled", 32'(irq), 32'd1);
      read_chk("t5_masked2", A_MSK, 32'h2);
      bus_write(A_EN, 32'h0);
      tick();
      chk("t5_irq_disabled", 32'(irq), 32'd0);

      // Set and W1C on the same edge: set wins.
      bus_write(A_ST, 32'h3);
      bus_write(A_EN, 32'h1);
      repeat (20) tick();
      trig = 24'h1;
      tick();
      trig = '0;
      tick();
      bus_addr = A_ST; bus_wr_data = 32'h1; bus_we = 1'b1;
      tick();
      chk("t6_wr_ack", 32'(bus_wr_ack), 32'd1);
      bus_we = 1'b0;
      read_chk("t6_status_kept", A_ST, 32'h1);
      repeat (14) tick();
      chk("t6_bus_irq_early", 32'(bus_irq), 32'd0);
      tick();
      chk("t6_bus_irq_rise", 32'(bus_irq), 32'd1);
      chk("t6_irq_rise", 32'(irq), 32'd1);
      bus_write(A_ST, 32'h1);
      tick();
      chk("t6_bus_irq_fall", 32'(bus_irq), 32'd0);

      // Reset during a pending ack and with irq high.
      bus_write(A_EN, 32'h2);
      trig = 24'h2;
      tick();
      trig = '0;
      repeat (20) tick();
      chk("t7_irq_before", 32'(irq), 32'd1);
      bus_addr = A_ST; bus_re = 1'b1;
      tick();
      chk("t7_ack_before", 32'(bus_rd_ack), 32'd1);
      #2 bus_reset_l = 1'b0;
      #1;
      chk("t7_ack_dropped", 32'(bus_rd_ack), 32'd0);
      chk("t7_irq_dropped", 32'(irq), 32'd0);
      bus_re = 1'b0;
      tick();
      bus_reset_l = 1'b1;
      tick();
      chk("t7_no_ack_after", 32'(bus_rd_ack), 32'd0);
      read_chk("t7_enable_zero", A_EN, 32'h0);

      // Randomized run against the reference model.
      bus_reset_l = 1'b0;
      tick();
      bus_reset_l = 1'b1;
      model_reset();
      for (int n = 0; n < 3000; n++) begin
         int r;
         if ($urandom_range(0, 29) == 0) trig = trig ^ DW'(1 << $urandom_range(0, 7));
         r = $urandom_range(0, 9);
         bus_we = (r < 2);
         bus_re = (r >= 2 && r < 4);
         bus_addr = (($urandom_range(0, 9) == 0) ? 16'h0080 : A_ST)
                    + 16'($urandom_range(0, 3) * 4);
         bus_wr_data = $urandom;
         model_step();
         tick();
         chk("rnd_irq", 32'(irq), 32'(e_irq));
         chk("rnd_bus_irq", 32'(bus_irq), 32'(e_irq));
         chk("rnd_rd_ack", 32'(bus_rd_ack), 32'(e_rack));
         chk("rnd_wr_ack", 32'(bus_wr_ack), 32'(e_wack));
         chk("rnd_rd_data", bus_rd_data, e_rdata);
      end
      bus_we = 1'b0; bus_re = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
